mem_responder: RTL



---
 rtl/mem_responder_if.sv | 31 +++
 rtl/mem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder_if
// Brief   : Cache-side line request / refill / writeback bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [3:0]  beat_idx;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        done;
  logic        err;

  modport master (
    output req_valid, req_we, req_addr, wr_valid, wr_data,
    input  req_ready, rd_valid, rd_data, beat_idx, wr_ready, done, err
  );

  modport slave (
    input  req_valid, req_we, req_addr, wr_valid, wr_data,
    output req_ready, rd_valid, rd_data, beat_idx, wr_ready, done, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder
// Brief   : Byte-wide backing memory answering cache line refills/writebacks.
//           Optional macro ADDR_CHECK_EN flags requests above the array.
// Revision: 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int MEM_AW     = 12,
  parameter int LINE_BYTES = 4,
  parameter int LATENCY    = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int BEAT_W = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BYTES - 1);
  localparam logic [15:0]       LINE_MASK = 16'(LINE_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_RBURST = 3'd2,
    S_WBURST = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [15:0]       base_q, base_d;
  logic              we_q, we_d;

  logic              req_ready_q, req_ready_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic [3:0]        beat_idx_q, beat_idx_d;
  logic              wr_ready_q, wr_ready_d;
  logic              done_q, done_d;
  logic              err_d;

  logic [7:0]        mem_q [0:(1<<MEM_AW)-1];

  logic [15:0]       w_rd_addr;
  logic [15:0]       w_wr_addr;
  logic              w_mem_we;

  // Bases are line aligned, so adding the beat offset never carries out of the line.
  assign w_rd_addr = base_d + 16'(beat_d);
  assign w_wr_addr = base_q + 16'(beat_q);
  assign w_mem_we  = (state_q == S_WBURST) && bus.wr_valid;

  generate
    if (MEM_AW < 16) begin : g_alias_hi
      logic w_unused_hi;
      assign w_unused_hi = ^{w_rd_addr[15:MEM_AW], w_wr_addr[15:MEM_AW]};
    end
  endgenerate

`ifdef ADDR_CHECK_EN
  logic w_addr_bad;
  logic err_q;

  generate
    if (MEM_AW < 16) begin : g_addr_chk
      assign w_addr_bad = |bus.req_addr[15:MEM_AW];
    end else begin : g_addr_full
      assign w_addr_bad = 1'b0;
    end
  endgenerate
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    base_d  = base_q;
    we_d    = we_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          base_d  = bus.req_addr & ~LINE_MASK;
          we_d    = bus.req_we;
          cnt_d   = CNT_W'(LATENCY - 1);
          beat_d  = '0;
          state_d = S_WAIT;
`ifdef ADDR_CHECK_EN
          if (w_addr_bad) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = we_q ? S_WBURST : S_RBURST;
          beat_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RBURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d = S_DONE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_WBURST: begin
        if (bus.wr_valid) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so every port is driven from a flop.
    req_ready_d = (state_d == S_IDLE);
    rd_valid_d  = (state_d == S_RBURST);
    wr_ready_d  = (state_d == S_WBURST);
    done_d      = (state_d == S_DONE);
    beat_idx_d  = (rd_valid_d || wr_ready_d) ? 4'(beat_d) : 4'd0;
    rd_data_d   = rd_valid_d ? mem_q[w_rd_addr[MEM_AW-1:0]] : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      base_q      <= '0;
      we_q        <= 1'b0;
      req_ready_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 8'd0;
      beat_idx_q  <= 4'd0;
      wr_ready_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      we_q        <= we_d;
      req_ready_q <= req_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      beat_idx_q  <= beat_idx_d;
      wr_ready_q  <= wr_ready_d;
      done_q      <= done_d;
    end
  end

  // The array is never cleared; an asserted reset forces IDLE, which blocks writes.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem_q[w_wr_addr[MEM_AW-1:0]] <= bus.wr_data;
    end
  end

`ifdef ADDR_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  logic w_unused_err;
  assign w_unused_err = err_d;
  assign bus.err      = 1'b0;
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.beat_idx  = beat_idx_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.done      = done_q;

endmodule
`default_nettype wire
